// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
//
// Purpose:
//   Writeback-side producer for the integer register file's single write port.
//   It merges single-cycle ALU results with in-order load responses into one
//   registered write per cycle (WE3/A3/WD3). It also tracks the destinations
//   of outstanding loads in a scoreboard, and from that drives the decode
//   stall for RAW hazards on rs1/rs2.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   alu_valid/rd/data ALU result offer; alu_ready = accepted this cycle
//   ld_issue_valid/rd load issued to memory; ld_issue_ready = tag FIFO not full
//   ld_resp_valid/data in-order load data (no backpressure)
//   rs1, rs2          decode source registers
//   stall             decode must hold (RAW on a busy register, or issue blocked)
//   WE3, A3, WD3      registered regfile write port
//   busy_mask         scoreboard, one bit per architectural register
//   resp_err          sticky: a response arrived with no load outstanding
// -----------------------------------------------------------------------------
module wb_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LD_DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         alu_ready,
  input  logic                         ld_issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    ld_issue_rd,
  output logic                         ld_issue_ready,
  input  logic                         ld_resp_valid,
  input  logic [DATA_WIDTH-1:0]        ld_resp_data,
  input  logic [REG_ADDR_WIDTH-1:0]    rs1,
  input  logic [REG_ADDR_WIDTH-1:0]    rs2,
  output logic                         stall,
  output logic                         WE3,
  output logic [REG_ADDR_WIDTH-1:0]    A3,
  output logic [DATA_WIDTH-1:0]        WD3,
  output logic [2**REG_ADDR_WIDTH-1:0] busy_mask,
  output logic                         resp_err
);

  localparam int NREGS = 2**REG_ADDR_WIDTH;
  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(LD_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;

  // Tag FIFO state
  logic [REG_ADDR_WIDTH-1:0] tag_q [LD_DEPTH];
  logic [LD_DEPTH-1:0]       slot_vld_q, slot_vld_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]            cnt_q, cnt_d;

  // Write port register
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0]     wd_q, wd_d;

  // Scoreboard and error flag
  logic [NREGS-1:0]          busy_q, busy_d;
  logic                      err_q, err_d;

  logic full, empty, push, pop, alu_take, waw_hit;
  logic [REG_ADDR_WIDTH-1:0] head_rd;

  assign full     = (cnt_q == DEPTH_CNT);
  assign empty    = (cnt_q == '0);
  assign push     = ld_issue_valid && !full;
  assign pop      = ld_resp_valid && !empty;
  assign head_rd  = tag_q[rd_ptr_q];
  assign alu_take = alu_valid && !pop;

  assign ld_issue_ready = !full;
  assign alu_ready      = !pop;

  // A committing write may only clear its busy bit when no load still held in
  // the FIFO targets the same register. Entries popped this very edge still
  // count: their data is about to sit in the write register, pending commit.
  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (slot_vld_q[i] && (tag_q[i] == a3_q)) waw_hit = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    slot_vld_d = slot_vld_q;
    if (push) begin
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
      slot_vld_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d             = rd_ptr_q + PTR_ONE;
      slot_vld_d[rd_ptr_q] = 1'b0;
    end
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  // Load response has priority. A write to x0 still consumes its source but
  // never raises WE3; A3/WD3 then keep their previous contents.
  always_comb begin
    we_d = 1'b0;
    a3_d = a3_q;
    wd_d = wd_q;
    if (pop) begin
      if (head_rd != '0) begin
        we_d = 1'b1;
        a3_d = head_rd;
        wd_d = ld_resp_data;
      end
    end else if (alu_take) begin
      if (alu_rd != '0) begin
        we_d = 1'b1;
        a3_d = alu_rd;
        wd_d = alu_data;
      end
    end
  end

  // Clear first so that a same-edge set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q && !waw_hit) busy_d[a3_q] = 1'b0;
    if (push && (ld_issue_rd != '0)) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign err_d = err_q || (ld_resp_valid && empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      slot_vld_q <= '0;
      we_q       <= 1'b0;
      a3_q       <= '0;
      wd_q       <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      slot_vld_q <= slot_vld_d;
      we_q       <= we_d;
      a3_q       <= a3_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Tag storage needs no reset: slot_vld_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= ld_issue_rd;
  end

  assign stall = (busy_q[rs1] && (rs1 != '0)) ||
                 (busy_q[rs2] && (rs2 != '0)) ||
                 (ld_issue_valid && full);

  assign WE3       = we_q;
  assign A3        = a3_q;
  assign WD3       = wd_q;
  assign busy_mask = busy_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  rs1, rs2;
  logic        stall;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] busy_mask;
  logic        resp_err;

  int nvec = 0;
  int nerr = 0;

  wb_scoreboard #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .WE3(WE3), .A3(A3), .WD3(WD3), .busy_mask(busy_mask), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_resp_valid = 0; ld_resp_data = 0;
    rs1 = 0; rs2 = 0;

    // Asynchronous reset asserted mid-cycle takes effect at once
    #3 rst_n = 1'b0;
    #1;
    check("rst_we3", WE3, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_err", resp_err, 0);
    check("rst_a3", A3, 0);
    check("rst_wd3", WD3, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_we3", WE3, 0);
    check("idle_issue_ready", ld_issue_ready, 1);

    // ALU write rd=5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 check("alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    check("alu_we3", WE3, 1);
    check("alu_a3", A3, 5);
    check("alu_wd3", WD3, 32'hDEADBEEF);
    tick();
    check("alu_we3_drop", WE3, 0);
    check("alu_a3_hold", A3, 5);

    // ALU write to x0 is consumed but never written
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    #1 check("alu0_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    check("alu0_we3", WE3, 0);

    // Load RAW on x7
    ld_issue_valid = 1; ld_issue_rd = 7; rs1 = 7;
    #1 check("raw_stall_before", stall, 0);
    tick();
    ld_issue_valid = 0;
    #1 check("raw_stall", stall, 1);
    check("raw_busy", busy_mask, 32'h80);
    tick();
    ld_resp_valid = 1; ld_resp_data = 32'h12345678;
    tick();
    ld_resp_valid = 0;
    check("raw_we3", WE3, 1);
    check("raw_a3", A3, 7);
    check("raw_wd3", WD3, 32'h12345678);
    check("raw_stall_pending", stall, 1);
    tick();
    check("raw_stall_clear", stall, 0);
    check("raw_busy_clear", busy_mask, 0);
    rs1 = 0;

    // Load response and ALU collide: load wins, ALU follows
    ld_issue_valid = 1; ld_issue_rd = 8;
    tick();
    ld_issue_valid = 0;
    ld_resp_valid = 1; ld_resp_data = 32'hAAAA;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    #1 check("col_alu_ready", alu_ready, 0);
    tick();
    ld_resp_valid = 0;
    check("col_ld_we3", WE3, 1);
    check("col_ld_a3", A3, 8);
    check("col_ld_wd3", WD3, 32'hAAAA);
    #1 check("col_alu_ready2", alu_ready, 1);
    tick();
    alu_valid = 0;
    check("col_alu_a3", A3, 3);
    check("col_alu_wd3", WD3, 32'h11);
    check("col_busy8", busy_mask[8], 0);
    tick();

    // Fill FIFO with 9,9,4,2 (WAW on x9)
    ld_issue_valid = 1; ld_issue_rd = 9;  tick();
    ld_issue_rd = 9;  tick();
    ld_issue_rd = 4;  tick();
    ld_issue_rd = 2;  tick();
    ld_issue_rd = 1;
    #1 check("full_ready", ld_issue_ready, 0);
    check("full_stall", stall, 1);
    check("full_busy", busy_mask, 32'h214);
    ld_issue_valid = 0;
    ld_resp_valid = 1; ld_resp_data = 32'h99;
    tick();
    ld_resp_valid = 0;
    check("waw1_a3", A3, 9);
    check("waw1_wd3", WD3, 32'h99);
    tick();
    check("waw1_busy9_kept", busy_mask[9], 1);
    check("waw_no_rd1", busy_mask[1], 0);
    ld_resp_valid = 1; ld_resp_data = 32'h9A;
    tick();
    ld_resp_valid = 0;
    check("waw2_wd3", WD3, 32'h9A);
    check("waw2_pending", busy_mask[9], 1);
    tick();
    check("waw2_busy9_clear", busy_mask[9], 0);
    ld_resp_valid = 1; ld_resp_data = 32'h44; tick();
    ld_resp_data = 32'h22;
    check("drain_a3_4", A3, 4);
    tick();
    ld_resp_valid = 0;
    check("drain_a3_2", A3, 2);
    check("drain_wd3_2", WD3, 32'h22);
    tick();
    check("drain_busy", busy_mask, 0);
    check("drain_ready", ld_issue_ready, 1);

    // Response with nothing outstanding
    ld_resp_valid = 1; ld_resp_data = 32'hBAD;
    tick();
    ld_resp_valid = 0;
    check("err_we3", WE3, 0);
    check("err_flag", resp_err, 1);
    tick();
    check("err_sticky", resp_err, 1);

    // Reset with two loads outstanding
    ld_issue_valid = 1; ld_issue_rd = 10; tick();
    ld_issue_rd = 11; tick();
    ld_issue_valid = 0;
    check("mid_busy", busy_mask, 32'hC00);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_mask, 0);
    check("mid_rst_err", resp_err, 0);
    check("mid_rst_we3", WE3, 0);
    tick();
    rst_n = 1'b1;
    ld_resp_valid = 1; ld_resp_data = 32'h77;
    tick();
    ld_resp_valid = 0;
    check("mid_fifo_empty_we3", WE3, 0);
    check("mid_fifo_empty_err", resp_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Writeback-side producer for the integer register file's single write port (WE3 / A3 / WD3).
- Merges single-cycle ALU results with delayed, in-order load responses into one registered write per cycle.
- Tracks destination registers of outstanding loads in a scoreboard and drives the decode-stage stall for RAW hazards on rs1/rs2.
- Sits between execute/LSU and regfile; decode consumes the stall.

Parameters:
- DATA_WIDTH, 32, register data width.
- REG_ADDR_WIDTH, 5, register index width (32 architectural registers).
- LD_DEPTH, 4, max outstanding loads (tag FIFO depth, power of 2, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- ld_issue_valid  in  1  load issued to memory
- ld_issue_rd  in  REG_ADDR_WIDTH  load destination register
- ld_issue_ready  out  1  tag FIFO can accept an issue
- ld_resp_valid  in  1  load data returned (in issue order, no backpressure)
- ld_resp_data  in  DATA_WIDTH  load data
- rs1  in  REG_ADDR_WIDTH  decode source 1
- rs2  in  REG_ADDR_WIDTH  decode source 2
- stall  out  1  decode must hold
- WE3  out  1  regfile write enable
- A3  out  REG_ADDR_WIDTH  regfile write address
- WD3  out  DATA_WIDTH  regfile write data
- busy_mask  out  2**REG_ADDR_WIDTH  scoreboard (debug)
- resp_err  out  1  sticky: response arrived with no outstanding load

Behaviour:
- Reset (async, rst_n=0):
  - WE3=0, A3=0, WD3=0.
  - busy_mask=0, tag FIFO empty, resp_err=0.
  - Outputs hold these values until the first posedge after rst_n rises.
  - Reset mid-operation discards all outstanding loads and any pending write.
- Tag FIFO: circular, LD_DEPTH entries of rd.
  - ld_issue_ready = !full. No pop-bypass when full, even if a response arrives that cycle.
  - Push when ld_issue_valid && ld_issue_ready. Pop when ld_resp_valid && !empty.
  - Push and pop may occur in the same cycle. Pointers wrap modulo LD_DEPTH.
- Write-port arbitration, per cycle:
  - Load response has priority over the ALU.
  - alu_ready = !(ld_resp_valid && !empty).
  - Selected source is registered: WE3/A3/WD3 valid exactly 1 cycle after acceptance. Regfile commits on the following edge.
  - Write with rd=0: consumed (FIFO pops / alu_ready handshake completes) but WE3 stays 0.
  - No source selected: WE3=0. A3/WD3 hold their previous values.
- Scoreboard, busy_mask[r]:
  - Set on the accepted-issue edge when r != 0.
  - Clear on the edge where WE3=1 && A3=r (the regfile commit edge), but only if no other tag-FIFO entry (excluding the popped one) still holds r, i.e. a WAW load is still pending.
  - Set and clear of the same r on the same edge: set wins.
  - busy_mask[0] is always 0.
- Pending commit: a load write sitting in the WE3 register keeps its busy bit set until that commit edge.
- stall (combinational) = (busy_mask[rs1] && rs1!=0) || (busy_mask[rs2] && rs2!=0) || (ld_issue_valid && !ld_issue_ready).
- Protocol error: ld_resp_valid while empty → response ignored, no write, resp_err set (sticky until reset).
- Latency: ALU result to regfile commit = 2 edges. Load response to busy bit clear = 2 edges.

Test Plan:
- Reset then idle: hold rst_n=0 mid-cycle → WE3=0, busy_mask=0, resp_err=0 immediately. After release with no stimulus, WE3 stays 0.
- ALU write: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle → alu_ready=1. Next cycle WE3=1, A3=5, WD3=0xDEADBEEF. ALU with rd=0 → WE3 stays 0.
- Load RAW: issue rd=7, drive rs1=7 → stall=1 from the next cycle. Response data=0x12345678 two cycles later → WE3=1/A3=7 one cycle later. stall deasserts the cycle after that commit.
- Collision: ld_resp_valid and alu_valid (rd=3, 0x11) in the same cycle → alu_ready=0, load written first. The ALU value holding valid next cycle is written one cycle later.
- Full/WAW: issue 4 loads to rd=9,9,4,2 → ld_issue_ready=0, a 5th issue raises stall. The first response (rd=9) leaves busy_mask[9]=1. The second clears it.
- Error and reset mid-flight: ld_resp_valid with FIFO empty → no WE3, resp_err=1. Assert rst_n=0 with 2 loads outstanding → FIFO empty, busy_mask=0.
